random_ca_parity_stream: RTL and testbench

RANDOM_CA_PARITY_STREAM -- requirements
Module: random_ca_parity_stream

---
 rtl/ca_pkg.sv | 16 +
 rtl/ca_rule_step.sv | 19 +
 rtl/random_ca_parity_stream.sv | 153 +++++++++++++++
 tb/tb_random_ca_parity_stream.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// Shared types and elementary-rule constants for the cellular-automaton parity stream.
package ca_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP,
    ST_RUN,
    ST_FAULT
  } ca_state_t;

  localparam logic [7:0] RULE_30  = 8'h1E;
  localparam logic [7:0] RULE_60  = 8'h3C;
  localparam logic [7:0] RULE_90  = 8'h5A;
  localparam logic [7:0] RULE_150 = 8'h96;
  localparam logic [7:0] RULE_204 = 8'hCC;

endpackage

// File: rtl/ca_rule_step.sv
// One combinational step of a 1-D elementary CA with wrap-around boundary.
module ca_rule_step
  import ca_pkg::*;
#(
  parameter int CA_W = 96
) (
  input  logic [CA_W-1:0] state,
  input  logic [7:0]      rule,
  output logic [CA_W-1:0] next_state
);

  // Neighbourhood index is {left, centre, right} with left = cell i+1.
  for (genvar i = 0; i < CA_W; i++) begin : g_cell
    localparam int L = (i + 1) % CA_W;
    localparam int R = (i + CA_W - 1) % CA_W;
    assign next_state[i] = rule[{state[L], state[i], state[R]}];
  end

endmodule

// File: rtl/random_ca_parity_stream.sv
// Rule-scheduled cellular-automaton random word source with warmup,
// ready/valid output and a sticky repetition-health fault.
module random_ca_parity_stream
  import ca_pkg::*;
#(
  parameter int                              WIDTH        = 32,
  parameter int                              PARITY_WIDTH = 3,
  parameter int                              RULE_COUNT   = 4,
  parameter logic [8*RULE_COUNT-1:0]         RULES        = {RULE_150, RULE_90, RULE_60, RULE_30},
  parameter int                              RULE_PERIOD  = 2,
  parameter int                              WARMUP       = 64,
  parameter int                              REPEAT_LIMIT = 8,
  parameter logic [WIDTH*PARITY_WIDTH-1:0]   DEFAULT_SEED = {{(WIDTH*PARITY_WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ce,
  input  logic                            seed_load,
  input  logic [WIDTH*PARITY_WIDTH-1:0]   seed,
  output logic [WIDTH-1:0]                out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            fault
);

  localparam int CA_W   = WIDTH * PARITY_WIDTH;
  localparam int IDX_W  = (RULE_COUNT > 1) ? $clog2(RULE_COUNT) : 1;
  localparam int PER_W  = $clog2(RULE_PERIOD + 1);
  localparam int WARM_W = $clog2(WARMUP + 1);
  localparam int REP_W  = $clog2(REPEAT_LIMIT + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(RULE_COUNT - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(RULE_PERIOD - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [REP_W-1:0]  REP_TRIP  = REP_W'(REPEAT_LIMIT - 1);

  ca_state_t          state, next_state;
  logic [CA_W-1:0]    ca, ca_next;
  logic [7:0]         rule_tab [RULE_COUNT];
  logic [7:0]         rule;
  logic [IDX_W-1:0]   rule_idx;
  logic [PER_W-1:0]   period_cnt;
  logic [WARM_W-1:0]  warm_cnt;
  logic [REP_W-1:0]   repeat_cnt, rep_next;
  logic [WIDTH-1:0]   word_next;
  logic [WIDTH-1:0]   prev_word;
  logic               prev_valid;
  logic               step, accept, hit_limit;

  for (genvar k = 0; k < RULE_COUNT; k++) begin : g_rule
    assign rule_tab[k] = RULES[8*k +: 8];
  end

  assign rule = rule_tab[rule_idx];
  assign busy = (state == ST_WARMUP);

  ca_rule_step #(.CA_W(CA_W)) u_step (
    .state      (ca),
    .rule       (rule),
    .next_state (ca_next)
  );

  // Each output bit folds PARITY_WIDTH cells; even bits are inverted so an
  // all-zero CA never yields an all-zero word.
  always_comb begin
    word_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      word_next[i] = ^ca_next[i*PARITY_WIDTH +: PARITY_WIDTH] ^ (i % 2 == 0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_WARMUP;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    step       = 1'b0;
    accept     = 1'b0;
    hit_limit  = 1'b0;
    rep_next   = '0;
    case (state)
      ST_WARMUP: begin
        step = ce;
        if (ce && warm_cnt == WARM_LAST) next_state = ST_RUN;
      end
      ST_RUN: begin
        accept = out_valid && out_ready;
        if (accept && prev_valid && out_data == prev_word) rep_next = repeat_cnt + 1'b1;
        hit_limit = accept && (rep_next == REP_TRIP);
        step      = ce && (!out_valid || out_ready) && !hit_limit;
        if (hit_limit) next_state = ST_FAULT;
      end
      default: ;
    endcase
    if (seed_load) next_state = ST_WARMUP;
  end

  // A reseed drops any in-flight handshake: nothing below it runs that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ca         <= DEFAULT_SEED;
      rule_idx   <= '0;
      period_cnt <= '0;
      warm_cnt   <= '0;
      repeat_cnt <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      fault      <= 1'b0;
      prev_word  <= '0;
      prev_valid <= 1'b0;
    end else if (seed_load) begin
      ca         <= (seed == '0) ? DEFAULT_SEED : seed;
      rule_idx   <= '0;
      period_cnt <= '0;
      warm_cnt   <= '0;
      repeat_cnt <= '0;
      out_valid  <= 1'b0;
      fault      <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      if (step) begin
        ca <= ca_next;
        if (period_cnt == PER_LAST) begin
          period_cnt <= '0;
          rule_idx   <= (rule_idx == IDX_LAST) ? '0 : rule_idx + 1'b1;
        end else begin
          period_cnt <= period_cnt + 1'b1;
        end
      end
      if (state == ST_WARMUP && ce) begin
        warm_cnt <= (warm_cnt == WARM_LAST) ? '0 : warm_cnt + 1'b1;
      end
      if (accept) begin
        prev_word  <= out_data;
        prev_valid <= 1'b1;
        repeat_cnt <= rep_next;
      end
      if (hit_limit) begin
        out_valid <= 1'b0;
        fault     <= 1'b1;
      end else if (step && state == ST_RUN) begin
        out_data  <= word_next;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_random_ca_parity_stream.sv
// Directed self-checking bench for random_ca_parity_stream (12-cell CA, 4-bit words).
module tb_random_ca_parity_stream;

  localparam int W  = 4;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst, ce, seed_load, out_ready;
  logic [CW-1:0] seed;
  logic [W-1:0]  out_data;
  logic          out_valid, busy, fault;

  logic          rst2, ce2, seed_load2, out_ready2;
  logic [CW-1:0] seed2;
  logic [W-1:0]  out_data2;
  logic          out_valid2, busy2, fault2;

  int assertions = 0;
  int failures   = 0;

  // Reference model state
  logic [CW-1:0] m_ca;
  int            m_idx, m_per, m_warm, m_st, m_rep;
  logic [W-1:0]  m_data, m_prev;
  logic          m_valid, m_fault, m_prevv;
  logic [7:0]    rt [4];
  logic [W-1:0]  post_reset [6];

  always #5 clk = ~clk;

  random_ca_parity_stream #(
    .WIDTH(4), .PARITY_WIDTH(3), .RULE_COUNT(4), .RULE_PERIOD(2),
    .WARMUP(8), .REPEAT_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .seed_load(seed_load), .seed(seed),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .fault(fault)
  );

  random_ca_parity_stream #(
    .WIDTH(4), .PARITY_WIDTH(3), .RULE_COUNT(4), .RULES({4{8'hCC}}),
    .RULE_PERIOD(2), .WARMUP(8), .REPEAT_LIMIT(4)
  ) dut2 (
    .clk(clk), .rst(rst2), .ce(ce2), .seed_load(seed_load2), .seed(seed2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .busy(busy2), .fault(fault2)
  );

  function automatic logic [CW-1:0] ca_step(input logic [CW-1:0] c, input logic [7:0] r);
    logic [CW-1:0] n;
    logic [2:0]    nb;
    n = '0;
    for (int i = 0; i < CW; i++) begin
      nb   = {c[(i + 1) % CW], c[i], c[(i + CW - 1) % CW]};
      n[i] = r[nb];
    end
    return n;
  endfunction

  function automatic logic [W-1:0] word_of(input logic [CW-1:0] c);
    logic [W-1:0] w;
    int           ones;
    for (int i = 0; i < W; i++) begin
      ones = 0;
      for (int j = 0; j < 3; j++) ones += int'(c[i*3 + j]);
      w[i] = ((ones % 2) == 1) ^ ((i % 2) == 0);
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    m_ca = ca_step(m_ca, rt[m_idx]);
    m_per++;
    if (m_per == 2) begin
      m_per = 0;
      m_idx = (m_idx + 1) % 4;
    end
  endtask

  // Advance the reference model by one clock edge given the inputs it saw.
  task automatic model_edge(input logic r, input logic c, input logic sl,
                            input logic [CW-1:0] s, input logic rdy);
    logic acc, trip;
    if (r) begin
      m_ca = 12'h001; m_idx = 0; m_per = 0; m_warm = 0; m_rep = 0; m_st = 0;
      m_data = '0; m_valid = 0; m_fault = 0; m_prev = '0; m_prevv = 0;
    end else if (sl) begin
      m_ca = (s == '0) ? 12'h001 : s;
      m_idx = 0; m_per = 0; m_warm = 0; m_rep = 0; m_st = 0;
      m_valid = 0; m_fault = 0; m_prevv = 0;
    end else if (m_st == 0) begin
      if (c) begin
        model_step();
        m_warm++;
        if (m_warm == 8) begin
          m_warm = 0;
          m_st = 1;
        end
      end
    end else if (m_st == 1) begin
      acc  = m_valid && rdy;
      trip = 1'b0;
      if (acc) begin
        if (m_prevv && m_data == m_prev) m_rep++;
        else m_rep = 0;
        m_prev  = m_data;
        m_prevv = 1'b1;
        if (m_rep == 3) trip = 1'b1;
      end
      if (trip) begin
        m_valid = 0; m_fault = 1; m_st = 2;
      end else if (c && (!m_valid || rdy)) begin
        model_step();
        m_data  = word_of(m_ca);
        m_valid = 1;
      end else if (acc) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic checkOutput();
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("busy",      32'(busy),      32'(m_st == 0));
    chk("fault",     32'(fault),     32'(m_fault));
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic sl,
                               input logic [CW-1:0] s, input logic rdy);
    rst = r; ce = c; seed_load = sl; seed = s; out_ready = rdy;
    @(posedge clk);
    model_edge(r, c, sl, s, rdy);
    #1;
    checkOutput();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    logic [CW-1:0] hold_ca;
    int            hold_idx;
    logic [W-1:0]  hold_word;

    rt[0] = 8'h1E; rt[1] = 8'h3C; rt[2] = 8'h5A; rt[3] = 8'h96;
    rst2 = 1'b1; ce2 = 1'b0; seed_load2 = 1'b0; seed2 = '0; out_ready2 = 1'b0;

    // Reset state, and reset winning over a simultaneous seed load
    applyStimulus(1, 0, 0, 12'h000, 0);
    applyStimulus(1, 0, 0, 12'h000, 0);
    applyStimulus(1, 1, 1, 12'hABC, 1);
    chk("rst_over_seed_ca", 32'(dut.ca), 32'h001);

    // Warmup: rule 30 on a single live cell gives cells 11,1,0
    applyStimulus(0, 1, 0, 12'h000, 1);
    chk("first_step_ca", 32'(dut.ca), 32'h803);
    for (int k = 2; k <= 8; k++) applyStimulus(0, 1, 0, 12'h000, 1);
    chk("warmup_done_valid", 32'(out_valid), 32'h0);

    // Free-running words with full throughput
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 1, 0, 12'h000, 1);
      if (k < 6) post_reset[k] = m_data;
    end
    chk("run_rule_idx", 32'(dut.rule_idx), 32'(m_idx));

    // Backpressure: everything holds
    hold_ca = m_ca; hold_idx = m_idx; hold_word = m_data;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 0, 12'h000, 0);
      chk("stall_ca",   32'(dut.ca),       32'(hold_ca));
      chk("stall_idx",  32'(dut.rule_idx), 32'(hold_idx));
      chk("stall_data", 32'(out_data),     32'(hold_word));
    end
    applyStimulus(0, 1, 0, 12'h000, 1);
    applyStimulus(0, 1, 0, 12'h000, 1);

    // Zero seed during a live handshake: default seed, sequence restarts
    applyStimulus(0, 1, 1, 12'h000, 1);
    chk("seed0_ca", 32'(dut.ca), 32'h001);
    for (int k = 0; k < 8; k++) applyStimulus(0, 1, 0, 12'h000, 1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1, 0, 12'h000, 1);
      chk("reseed_replay", 32'(out_data), 32'(post_reset[k]));
    end

    // Reseed in the middle of warmup restarts the warmup count
    applyStimulus(0, 1, 1, 12'h5A3, 1);
    for (int k = 0; k < 5; k++) applyStimulus(0, 1, 0, 12'h000, 1);
    applyStimulus(0, 1, 1, 12'h3C1, 1);
    chk("reseed_ca", 32'(dut.ca), 32'h3C1);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      applyStimulus(0, 1, 0, 12'h000, 1);
      cnt++;
    end
    chk("reseed_latency", 32'(cnt), 32'd9);

    // Clock enable toggling: one word per enabled cycle, rule index wraps
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 1, 0, 12'h000, 1);
      chk("ce_rule_idx", 32'(dut.rule_idx), 32'(m_idx));
      applyStimulus(0, 0, 0, 12'h000, 1);
      chk("ce_low_valid", 32'(out_valid), 32'h0);
    end

    // Identity rule: constant word 4'h4 trips the repetition fault on the 4th accept
    ce = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst2 = 1'b0; ce2 = 1'b1; out_ready2 = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      if (k == 8) chk("r204_busy_end", 32'(busy2), 32'h0);
      if (k == 9) begin
        chk("r204_first_valid", 32'(out_valid2), 32'h1);
        chk("r204_word", 32'(out_data2), 32'h4);
      end
      if (k == 12) begin
        chk("r204_no_fault_yet", 32'(fault2), 32'h0);
        chk("r204_valid_before", 32'(out_valid2), 32'h1);
      end
    end
    chk("r204_fault", 32'(fault2), 32'h1);
    chk("r204_valid_drop", 32'(out_valid2), 32'h0);
    @(posedge clk); #1;
    chk("r204_fault_sticky", 32'(fault2), 32'h1);
    seed_load2 = 1'b1;
    @(posedge clk); #1;
    seed_load2 = 1'b0;
    chk("r204_fault_clear", 32'(fault2), 32'h0);
    chk("r204_busy_again", 32'(busy2), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
